// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit WISC pipeline.
// Optional misaligned-redirect detection (adds port err) is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;
    logic        halted_q;

    logic [15:0] pc_inc;
    logic        is_halt_op;
    logic        redirect_bad;

    assign pc_inc     = pc_q + 16'd2;
    assign is_halt_op = (imem_data[15:11] == HALT_OP);

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;
    assign redirect_bad = redirect_pc[0];
    assign err          = err_q;
`else
    assign redirect_bad = 1'b0;
`endif

    // The request is suppressed during reset so memory never sees a stale-PC read.
    assign imem_addr    = pc_q;
    assign imem_rd      = !rst && (state_q != ST_HALT);
    assign instr_out    = instr_q;
    assign pc_plus2_out = pc_plus2_q;
    assign valid_out    = valid_q;
    assign halted       = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else if (redirect) begin
            // A redirect always wins, even out of HALT: that HALT was younger than the redirecting instruction.
            pc_q       <= redirect_pc;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
            if (redirect_bad) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                err_q    <= 1'b1;
`endif
            end else begin
                state_q  <= ST_FETCH;
                halted_q <= 1'b0;
            end
        end else if (stall) begin
            // Returned data is dropped; reads are idempotent so the same PC is simply asked for again.
            if (state_q != ST_HALT) begin
                state_q <= ST_WAIT;
            end
        end else if (state_q == ST_HALT) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (imem_done) begin
            instr_q    <= imem_data;
            pc_plus2_q <= pc_inc;
            valid_q    <= 1'b1;
            if (is_halt_op) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end else begin
                pc_q    <= pc_inc;
                state_q <= ST_FETCH;
            end
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            state_q <= ST_WAIT;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a spec-level model pushes expected IF/ID contents each cycle,
// which are popped and compared once the DUT has clocked.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic [15:0] imemData;
    logic        imemDone;
    logic [15:0] imemAddr;
    logic        imemRd;
    logic [15:0] instrOut;
    logic [15:0] pcPlus2Out;
    logic        validOut;
    logic        haltedOut;
    logic        errOut;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp2;
        logic        valid;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t expQ[$];

    // Reference model state (0 = FETCH, 1 = WAIT, 2 = HALT)
    logic [15:0] mPc;
    int          mState;
    logic [15:0] mInstr;
    logic [15:0] mPcp2;
    logic        mValid;
    logic        mHalted;
    logic        mErr;
    logic        mKnown = 1'b0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirectPc),
        .imem_data    (imemData),
        .imem_done    (imemDone),
        .imem_addr    (imemAddr),
        .imem_rd      (imemRd),
        .instr_out    (instrOut),
        .pc_plus2_out (pcPlus2Out),
        .valid_out    (validOut),
        .halted       (haltedOut)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .err          (errOut)
`endif
    );

`ifndef FETCH_ALIGN_CHECK_EN
    assign errOut = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and score the registered outputs after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [15:0] rpc, input logic dn, input logic [15:0] dat);
        exp_t e;
        @(negedge clk);
        rst        = r;
        stall      = s;
        redirect   = rd;
        redirectPc = rpc;
        imemDone   = dn;
        imemData   = dat;
        #1;
        checkOutput("imem_rd", {15'd0, imemRd}, {15'd0, (!r && mKnown && mState != 2) ? 1'b1 : 1'b0});
        if (mKnown && !r) checkOutput("imem_addr", imemAddr, mPc);

        if (r) begin
            mPc = 16'h0000; mState = 0; mInstr = 16'h0800; mPcp2 = 16'h0000;
            mValid = 1'b0; mHalted = 1'b0; mErr = 1'b0; mKnown = 1'b1;
        end else if (rd) begin
            mPc = rpc; mInstr = 16'h0800; mValid = 1'b0; mPcp2 = 16'h0000;
            mState = 0; mHalted = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc[0]) begin
                mErr = 1'b1; mState = 2; mHalted = 1'b1;
            end
`endif
        end else if (s) begin
            if (mState != 2) mState = 1;
        end else if (mState == 2) begin
            mInstr = 16'h0800; mValid = 1'b0;
        end else if (dn) begin
            mInstr = dat; mPcp2 = mPc + 16'd2; mValid = 1'b1;
            if (dat[15:11] == 5'b00000) begin
                mState = 2; mHalted = 1'b1;
            end else begin
                mPc = mPc + 16'd2; mState = 0;
            end
        end else begin
            mInstr = 16'h0800; mValid = 1'b0; mState = 1;
        end

        e.instr = mInstr; e.pcp2 = mPcp2; e.valid = mValid; e.halted = mHalted; e.err = mErr;
        expQ.push_back(e);

        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("instr_out", instrOut, e.instr);
            checkOutput("pc_plus2_out", pcPlus2Out, e.pcp2);
            checkOutput("valid_out", {15'd0, validOut}, {15'd0, e.valid});
            checkOutput("halted", {15'd0, haltedOut}, {15'd0, e.halted});
`ifdef FETCH_ALIGN_CHECK_EN
            checkOutput("err", {15'd0, errOut}, {15'd0, e.err});
`endif
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rdata;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0; imemData = 16'h0; imemDone = 1'b0;

        // Reset, including a memory response arriving during reset
        applyStimulus(1, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(1, 0, 0, 16'h0, 1, 16'h4321);
        checkOutput("reset_instr", instrOut, 16'h0800);
        checkOutput("reset_addr", imemAddr, 16'h0000);

        // Three back-to-back single-cycle fetches
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h4001);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h4802);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h5003);
        checkOutput("tp_instr3", instrOut, 16'h5003);
        checkOutput("tp_pcp2_3", pcPlus2Out, 16'h0006);

        // Memory wait of two cycles at 0x0010
        applyStimulus(0, 0, 1, 16'h0010, 1, 16'hAAAA);
        applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h6004);
        checkOutput("tp_wait_pc", imemAddr, 16'h0012);

        // Stall with memory answering: data discarded and refetched
        applyStimulus(0, 0, 1, 16'h0020, 0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0, 1, 16'h7777);
        applyStimulus(0, 1, 0, 16'h0, 1, 16'h7777);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h7005);
        checkOutput("tp_stall_pcp2", pcPlus2Out, 16'h0022);

        // Redirect beats a simultaneous stall
        applyStimulus(0, 1, 1, 16'h0100, 1, 16'h1111);
        checkOutput("tp_redir_addr", imemAddr, 16'h0100);

        // HALT at 0x0008, idle in HALT (with a stall), then redirect out
        applyStimulus(0, 0, 1, 16'h0008, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h0000);
        checkOutput("tp_halt_addr", imemAddr, 16'h0008);
        applyStimulus(0, 1, 0, 16'h0, 1, 16'h2222);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h2222);
        applyStimulus(0, 0, 1, 16'h0040, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h1234);

        // PC wraparound
        applyStimulus(0, 0, 1, 16'hFFFE, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h2345);
        checkOutput("tp_wrap_pcp2", pcPlus2Out, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h3456);

        // Misaligned redirect
        applyStimulus(0, 0, 1, 16'h0031, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h4567);
        applyStimulus(0, 0, 1, 16'h0050, 0, 16'h0);
        applyStimulus(0, 0, 0, 16'h0, 1, 16'h5678);

        // Reset mid-wait, with a redirect requested in the same cycle
        applyStimulus(0, 0, 0, 16'h0, 0, 16'h0);
        applyStimulus(1, 0, 1, 16'h0200, 1, 16'h6789);

        // Random traffic, with occasional HALT words and redirects
        for (int i = 0; i < 120; i++) begin
            rdata = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rdata[15:11] = 5'b00000;
            applyStimulus(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                          16'($urandom), ($urandom_range(0, 2) != 0), rdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
